inst_fetch_unit: RTL

- Instruction fetch stage sitting directly upstream of the core pipeline's instruction decode input.
- Owns the fetch PC and issues word requests to instruction memory over a req/ack handshake.
- Buffers returned words in a small prefetch FIFO and presents them, with their PC, to the decode stage under a valid/ready handshake.
- Supports pipeline halt and redirect (jump/branch) with flush and discard of in-flight responses.

---
 rtl/inst_fetch_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding imem requests and
// buffers returned words in a prefetch FIFO for decode. Optional counters: IFU_PERF_CNT_EN.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [15:0] perf_discard_cnt
`endif
);

    localparam int unsigned     IdxW   = $clog2(FIFO_DEPTH);
    localparam int unsigned     PtrW   = IdxW + 1;
    localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
    localparam logic [PtrW-1:0] DepthP = PtrW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StDiscard} state_e;

    state_e          state_q, state_d;
    logic            req_q, req_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]     data_mem_q [FIFO_DEPTH];
    logic [31:0]     pc_mem_q   [FIFO_DEPTH];
    logic [PtrW-1:0] occupancy;
    logic [31:0]     pc_inc;
    logic            push, pop, drop;
    logic            unused_redirect_lsb;

    assign occupancy           = wr_ptr_q - rd_ptr_q;
    assign pc_inc              = fetch_pc_q + 32'd4;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign inst_valid = (wr_ptr_q != rd_ptr_q);
    assign inst_data  = data_mem_q[rd_ptr_q[IdxW-1:0]];
    assign inst_pc    = pc_mem_q[rd_ptr_q[IdxW-1:0]];

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        push       = 1'b0;
        drop       = 1'b0;
        pop        = inst_valid && inst_ready && !halt;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        case (state_q)
            StIdle: begin
                if (!redirect_valid && !halt && occupancy < DepthP) begin
                    state_d = StReq;
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                end
            end
            StReq: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        drop    = 1'b1;
                        state_d = StIdle;
                        req_d   = 1'b0;
                    end else begin
                        push       = 1'b1;
                        wr_ptr_d   = wr_ptr_q + PtrOne;
                        fetch_pc_d = pc_inc;
                        // Space is judged after this cycle's push and pop: zero-bubble streaming.
                        if (!halt && (wr_ptr_d - rd_ptr_d) < DepthP) begin
                            addr_d = pc_inc;
                        end else begin
                            state_d = StIdle;
                            req_d   = 1'b0;
                        end
                    end
                end else if (redirect_valid) begin
                    state_d = StDiscard;
                end
            end
            StDiscard: begin
                if (imem_ack) begin
                    drop    = 1'b1;
                    state_d = StIdle;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
            end
        endcase
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            wr_ptr_d   = wr_ptr_q;
            rd_ptr_d   = wr_ptr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_mem_q <= '{default: '0};
            pc_mem_q   <= '{default: '0};
        end else if (push) begin
            data_mem_q[wr_ptr_q[IdxW-1:0]] <= imem_rdata;
            pc_mem_q[wr_ptr_q[IdxW-1:0]]   <= fetch_pc_q;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [15:0] discard_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q   <= '0;
            discard_cnt_q <= '0;
        end else begin
            if (push && fetch_cnt_q != '1) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (drop && discard_cnt_q != '1) begin
                discard_cnt_q <= discard_cnt_q + 16'd1;
            end
        end
    end

    assign perf_fetch_cnt   = fetch_cnt_q;
    assign perf_discard_cnt = discard_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule
